// File: rtl/mpsoc_ahb3_ext_arbiter_if.sv
// ----------------------------------------------------------------------------
// mpsoc_ahb3_ext_arbiter_if
// AHB3-Lite link used on every side of the external-port arbiter.
//
// Signals:
//   HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
//                 address/data-phase request, driven by the bus master
//   HRDATA        read data returned to the master
//   HREADY        ready: on a master link it is the ready returned to the
//                 master; on the slave link it is the ready broadcast to the
//                 slave by the arbiter
//   HREADYOUT     slave ready output (used on the slave link only)
//   HRESP         transfer response
//
// Modports:
//   master  the side that issues transfers (arbiter towards the slave)
//   slave   the side that answers transfers (arbiter towards each master)
// ----------------------------------------------------------------------------
interface mpsoc_ahb3_ext_arbiter_if #(
    parameter int PLEN = 32,
    parameter int XLEN = 32
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic [XLEN-1:0] HRDATA;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/mpsoc_ahb3_ext_arbiter.sv
// ----------------------------------------------------------------------------
// mpsoc_ahb3_ext_arbiter
// Two-master to one-slave AHB3-Lite arbiter. Master 0 is the tile external
// port, master 1 a loader/debug master, the slave a single-port RAM. Each
// master sees an ordinary AHB3-Lite slave; contention is turned into wait
// states by parking the losing address phase in a per-master hold register.
// Arbitration is round-robin per transfer; SEQ/BUSY and locked sequences keep
// the grant with the current owner.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   m0    link from master 0 (arbiter acts as its slave)
//   m1    link from master 1 (arbiter acts as its slave)
//   s     link to the shared slave (arbiter acts as its master)
// ----------------------------------------------------------------------------
module mpsoc_ahb3_ext_arbiter #(
    parameter int PLEN = 32,
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mpsoc_ahb3_ext_arbiter_if.slave  m0,
    mpsoc_ahb3_ext_arbiter_if.slave  m1,
    mpsoc_ahb3_ext_arbiter_if.master s
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic            write;
        logic [2:0]      size;
        logic [2:0]      burst;
        logic [3:0]      prot;
        logic [1:0]      trans;
        logic            lock;
    } addr_phase_t;

    addr_phase_t live_0, live_1;
    addr_phase_t hold_0, hold_1;
    addr_phase_t src_0, src_1, owner_src, win_src;

    logic [1:0] pend_q;
    logic       dvalid_q;
    logic       downer_q;
    logic       owner_q;
    logic       rr_q;
    logic       lock_q;

    logic       rdy_0, rdy_1;
    logic [1:0] live_req;
    logic [1:0] req;
    logic       src_sel_0, src_sel_1;
    logic       owner_sel, owner_cont;
    logic       grant, win, flip;
    logic       win_sel;
    logic [1:0] fwd_trans;
    logic       fwd_ok;
    logic [1:0] cap;

    assign live_0 = '{addr: m0.HADDR, write: m0.HWRITE, size: m0.HSIZE,
                      burst: m0.HBURST, prot: m0.HPROT, trans: m0.HTRANS,
                      lock: m0.HMASTLOCK};
    assign live_1 = '{addr: m1.HADDR, write: m1.HWRITE, size: m1.HSIZE,
                      burst: m1.HBURST, prot: m1.HPROT, trans: m1.HTRANS,
                      lock: m1.HMASTLOCK};

    // Ready seen by each master: the slave's own ready while that master owns
    // the data phase, otherwise stalled only while a parked request waits.
    always_comb begin
        rdy_0 = !pend_q[0];
        rdy_1 = !pend_q[1];
        if (dvalid_q && !downer_q) rdy_0 = s.HREADYOUT;
        if (dvalid_q &&  downer_q) rdy_1 = s.HREADYOUT;
    end

    always_comb begin
        live_req[0] = m0.HSEL & m0.HTRANS[1] & rdy_0 & ~pend_q[0];
        live_req[1] = m1.HSEL & m1.HTRANS[1] & rdy_1 & ~pend_q[1];
        req         = pend_q | live_req;

        src_0     = pend_q[0] ? hold_0 : live_0;
        src_1     = pend_q[1] ? hold_1 : live_1;
        src_sel_0 = pend_q[0] | m0.HSEL;
        src_sel_1 = pend_q[1] | m1.HSEL;

        owner_src  = owner_q ? src_1 : src_0;
        owner_sel  = owner_q ? src_sel_1 : src_sel_0;
        owner_cont = owner_sel &&
                     (owner_src.trans == HTRANS_SEQ || owner_src.trans == HTRANS_BUSY);

        grant = 1'b0;
        win   = owner_q;
        flip  = 1'b0;
        if (owner_cont || lock_q) begin
            // Bursts and locked sequences stay with the owner, even if the
            // owner has gone idle: that idle cycle is what releases the lock.
            grant = 1'b1;
            win   = owner_q;
        end else if (req[0] && req[1]) begin
            grant = 1'b1;
            win   = rr_q;
            flip  = 1'b1;
        end else if (req[0]) begin
            grant = 1'b1;
            win   = 1'b0;
        end else if (req[1]) begin
            grant = 1'b1;
            win   = 1'b1;
        end

        win_src   = win ? src_1 : src_0;
        win_sel   = win ? src_sel_1 : src_sel_0;
        fwd_trans = win_sel ? win_src.trans : HTRANS_IDLE;
        fwd_ok    = s.HREADYOUT & grant;

        // A request accepted by its master but not sent on this cycle is parked.
        cap[0] = live_req[0] & ~(fwd_ok & ~win);
        cap[1] = live_req[1] & ~(fwd_ok &  win);
    end

    // Slave side. The request is also masked during reset so a parked
    // transfer cannot reach the slave in the cycle it is being discarded.
    assign s.HSEL      = fwd_ok & ~rst;
    assign s.HTRANS    = (fwd_ok && !rst) ? fwd_trans : HTRANS_IDLE;
    assign s.HADDR     = win_src.addr;
    assign s.HWRITE    = win_src.write;
    assign s.HSIZE     = win_src.size;
    assign s.HBURST    = win_src.burst;
    assign s.HPROT     = win_src.prot;
    assign s.HMASTLOCK = win_src.lock;
    assign s.HWDATA    = downer_q ? m1.HWDATA : m0.HWDATA;
    assign s.HREADY    = s.HREADYOUT;

    // Master side.
    assign m0.HRDATA = s.HRDATA;
    assign m1.HRDATA = s.HRDATA;
    assign m0.HREADY = rdy_0;
    assign m1.HREADY = rdy_1;
    assign m0.HRESP  = (dvalid_q && !downer_q) ? s.HRESP : 1'b0;
    assign m1.HRESP  = (dvalid_q &&  downer_q) ? s.HRESP : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= 2'b00;
            dvalid_q <= 1'b0;
            downer_q <= 1'b0;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            if (cap[0])
                pend_q[0] <= 1'b1;
            else if (fwd_ok && !win && pend_q[0])
                pend_q[0] <= 1'b0;

            if (cap[1])
                pend_q[1] <= 1'b1;
            else if (fwd_ok && win && pend_q[1])
                pend_q[1] <= 1'b0;

            if (s.HREADYOUT) begin
                // BUSY and IDLE are forwarded without opening a data phase.
                dvalid_q <= grant & fwd_trans[1];
                downer_q <= win;
                lock_q   <= grant & win_sel & win_src.lock;
                if (grant) owner_q <= win;
                if (flip)  rr_q    <= ~rr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap[0]) hold_0 <= live_0;
        if (cap[1]) hold_1 <= live_1;
    end

endmodule

// File: doc/mpsoc_ahb3_ext_arbiter.md
Name: mpsoc_ahb3_ext_arbiter

Overview:
Two-master to one-slave AHB3-Lite arbiter with per-master address-phase holding registers.
It sits between a tile's external AHB3 port (master 0, from riscv_mpsoc4d ahb3_ext_*) plus a loader/debug master (master 1) on one side, and one mpsoc_ahb3_spram slave on the other.
Each master sees a standard AHB3-Lite slave, with contention hidden behind wait states.
Arbitration is round-robin per transfer; bursts (SEQ/BUSY) and locked sequences keep the grant.

Parameters:
PLEN, 32, address width
XLEN, 32, data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_HSEL, m1_HSEL  in  1  master select
m0_HADDR, m1_HADDR  in  PLEN  address
m0_HWDATA, m1_HWDATA  in  XLEN  write data
m0_HWRITE, m1_HWRITE  in  1  write
m0_HSIZE/HBURST, m1_HSIZE/HBURST  in  3 each  size, burst
m0_HPROT, m1_HPROT  in  4  protection
m0_HTRANS, m1_HTRANS  in  2  transfer type
m0_HMASTLOCK, m1_HMASTLOCK  in  1  lock
m0_HRDATA, m1_HRDATA  out  XLEN  read data (broadcast of s_HRDATA)
m0_HREADY, m1_HREADY  out  1  per-master ready
m0_HRESP, m1_HRESP  out  1  per-master response
s_HSEL, s_HADDR, s_HWDATA, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT, s_HTRANS, s_HMASTLOCK  out  (as master)  slave request
s_HREADY  out  1  = s_HREADYOUT
s_HRDATA  in  XLEN  slave read data
s_HREADYOUT  in  1  slave ready
s_HRESP  in  1  slave response

Behaviour:
- Request req_k:
  - pend_k = 1, or
  - mk_HSEL & mk_HTRANS[1] & mk_HREADY.
  - The source is hold register k when pend_k = 1, otherwise the live inputs.
- Arbitration happens only in cycles with s_HREADYOUT = 1.
  - The winner's address-phase fields drive the slave. s_HSEL = 1.
  - Sticky rule: if owner issues SEQ/BUSY, or its last forwarded transfer had HMASTLOCK = 1, owner wins.
  - Otherwise round-robin: the single requester wins. With two requesters, master rr wins and rr flips to the other master.
  - owner <= winner.
  - Owner's BUSY is forwarded with no data phase.
- While s_HREADYOUT = 0, the slave sees HTRANS = IDLE, HSEL = 0 and no grant change.
- Capture: a live request accepted by master k (mk_HREADY = 1) but not forwarded that cycle is stored in hold_k (all address fields), and pend_k <= 1.
  - pend_k clears in the cycle hold_k is forwarded with s_HREADYOUT = 1.
- Data phase registers update when s_HREADYOUT = 1:
  - dvalid <= (forwarded HTRANS == NONSEQ or SEQ)
  - downer <= winner
- mk_HREADY / mk_HRESP:
  - If dvalid & downer == k: s_HREADYOUT / s_HRESP.
  - Else if pend_k: 0 / OKAY.
  - Else: 1 / OKAY.
- s_HWDATA = m[downer]_HWDATA. Masters hold HWDATA during their waited data phase.
- Error responses: the two-cycle s_HRESP = 1 pass through unchanged to downer.
- Latency:
  - Uncontended: 0 added cycles.
  - Losing a simultaneous request: 1 wait state per displaced transfer.
- Reset (synchronous, also mid-transfer) clears pend_0, pend_1, dvalid, owner = 0, rr = 0, lock flag.
  - Outputs after reset: s_HTRANS = IDLE, s_HSEL = 0, mk_HREADY = 1, mk_HRESP = 0.
  - In-flight transfers are discarded.
- IDLE or non-selected master inputs never generate req.

Test Plan:
- m0 only: NONSEQ write 0x10 = 0xDEADBEEF, then read 0x10 -> m0_HRDATA = 0xDEADBEEF, zero added waits, m1_HREADY = 1 throughout.
- Both NONSEQ in cycle N, rr = 0, zero-wait slave:
  - Slave sees m0's address in N and m1's (from hold) in N+1.
  - m1_HREADY = 0 in N+1 and 1 in N+2; rr = 1 afterwards.
- m0 INCR4 burst (NONSEQ + 3 SEQ) with m1 requesting at beat 2 -> four m0 beats contiguous at slave; m1 is forwarded in the cycle after m0's last SEQ.
- m0 locked pair (HMASTLOCK = 1, read 0x20 then write 0x20) with m1 contending -> no m1 transfer between them.
- s_HREADYOUT low 2 cycles during an m0 data phase, and m1 requests:
  - m1 is captured and s_HTRANS = IDLE during the waits.
  - m1 is forwarded on the first ready cycle, and m0_HREADY tracks s_HREADYOUT.
- rst asserted while pend_1 = 1 and dvalid = 1 -> next cycle pend cleared, s_HTRANS = IDLE, both mk_HREADY = 1, and no slave access occurs.
